// File: rtl/flash_sequencer.sv
// Plays back the stored colour sequence for the current round on the LEDs.
// Sets the timer speed, steps the segment index and reports completion to the fsm.
module flash_sequencer #(
  parameter int         ROUNDS_PER_SPEEDUP = 4,
  parameter logic [2:0] MAX_SPEED          = 3'd4,
  parameter int         ON_PULSES          = 1,
  parameter int         GAP_PULSES         = 1,
  parameter int         MAX_ROUND          = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] round,
  input  logic       pulse,
  input  logic [1:0] seg_colour,
  output logic [5:0] seg_idx,
  output logic [2:0] speed,
  output logic       load_speed,
  output logic [3:0] disp_o,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, ON, GAP, DONE} state_t;

  localparam logic [2:0] ON_LAST  = 3'(ON_PULSES - 1);
  localparam logic [2:0] GAP_LAST = 3'(GAP_PULSES - 1);
  localparam logic [5:0] MAX_RC   = 6'(MAX_ROUND);
  localparam logic [5:0] DIVISOR  = 6'(ROUNDS_PER_SPEEDUP);

  state_t     state_reg, state_next;
  logic [5:0] rc_reg, rc_next;
  logic [5:0] idx_reg, idx_next;
  logic [2:0] speed_reg, speed_next;
  logic [2:0] cnt_reg, cnt_next;

  logic [5:0] rc_in;
  logic [5:0] level;
  logic [2:0] speed_calc;
  logic       last_seg;

  // Speed level grows by one every ROUNDS_PER_SPEEDUP rounds, capped at MAX_SPEED.
  assign rc_in      = (round > MAX_RC) ? MAX_RC : round;
  assign level      = (rc_in - 6'd1) / DIVISOR;
  assign speed_calc = (level > {3'b000, MAX_SPEED}) ? MAX_SPEED : level[2:0];
  assign last_seg   = (idx_reg == rc_reg - 6'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rc_reg    <= '0;
      idx_reg   <= '0;
      speed_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rc_reg    <= rc_next;
      idx_reg   <= idx_next;
      speed_reg <= speed_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rc_next    = rc_reg;
    idx_next   = idx_reg;
    speed_next = speed_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          rc_next = rc_in;
          if (rc_in == 6'd0) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
            speed_next = speed_calc;
          end
        end
      end
      LOAD: begin
        // A pulse here is dropped: the timer is being reloaded this cycle.
        state_next = LEAD;
        idx_next   = '0;
        cnt_next   = '0;
      end
      LEAD: begin
        if (pulse) begin
          state_next = ON;
          cnt_next   = '0;
        end
      end
      ON: begin
        if (pulse) begin
          if (cnt_reg >= ON_LAST) begin
            state_next = GAP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end
      GAP: begin
        if (pulse) begin
          if (cnt_reg >= GAP_LAST) begin
            cnt_next = '0;
            if (last_seg) begin
              state_next = DONE;
            end else begin
              idx_next   = idx_reg + 6'd1;
              state_next = ON;
            end
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides any pulse-driven progress in the same cycle.
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      idx_next   = idx_reg;
      cnt_next   = '0;
    end
  end

  assign seg_idx    = idx_reg;
  assign speed      = speed_reg;
  assign load_speed = (state_reg == LOAD);
  assign busy       = (state_reg == LOAD) || (state_reg == LEAD) ||
                      (state_reg == ON)   || (state_reg == GAP);
  assign done       = (state_reg == DONE);
  assign disp_o     = (state_reg == ON) ? (4'b0001 << seg_colour) : 4'b0000;

endmodule

// File: tb/tb_flash_sequencer.sv
// Self-checking bench for flash_sequencer: speed table, pulse-count playback model,
// abort, reset and multi-pulse corner cases on a second instance (ON_PULSES=2).
module tb_flash_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start2, abort, pulse;
  logic [5:0] round;
  logic [1:0] seg_mem [64];

  logic [5:0] idx1, idx2;
  logic [2:0] spd1, spd2;
  logic       ld1, ld2, busy1, busy2, done1, done2;
  logic [3:0] disp1, disp2;
  logic [1:0] col1, col2;

  int total = 0;
  int bad   = 0;
  int last_spd [2];

  assign col1 = seg_mem[idx1];
  assign col2 = seg_mem[idx2];

  always #5 clk = ~clk;

  flash_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .round(round),
    .pulse(pulse), .seg_colour(col1), .seg_idx(idx1), .speed(spd1),
    .load_speed(ld1), .disp_o(disp1), .busy(busy1), .done(done1)
  );

  flash_sequencer #(.ON_PULSES(2), .GAP_PULSES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort), .round(round),
    .pulse(pulse), .seg_colour(col2), .seg_idx(idx2), .speed(spd2),
    .load_speed(ld2), .disp_o(disp2), .busy(busy2), .done(done2)
  );

  typedef struct {
    int rnd;
    int exp_speed;
  } speed_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic sample(input int inst, output int idx, output int spd, output int ld,
                        output int disp, output int bsy, output int dn);
    if (inst == 0) begin
      idx = idx1; spd = spd1; ld = ld1; disp = disp1; bsy = busy1; dn = done1;
    end else begin
      idx = idx2; spd = spd2; ld = ld2; disp = disp2; bsy = busy2; dn = done2;
    end
  endtask

  task automatic chk_zero(input int inst, input string tag);
    int idx, spd, ld, disp, bsy, dn;
    sample(inst, idx, spd, ld, disp, bsy, dn);
    chk({tag, "_idx"}, idx, 0);
    chk({tag, "_speed"}, spd, 0);
    chk({tag, "_load"}, ld, 0);
    chk({tag, "_disp"}, disp, 0);
    chk({tag, "_busy"}, bsy, 0);
    chk({tag, "_done"}, dn, 0);
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start = v;
    else start2 = v;
  endtask

  // Expected behaviour is a pure function of k, the number of pulses counted since
  // LOAD: one lead pulse, then per colour on_p lit pulses and gap_p dark pulses.
  task automatic play(input int inst, input int rnd, input int on_p, input int gap_p,
                      input int abort_at, input int reset_at, input bit pulse_in_load,
                      input bit restart_busy, input int spacing);
    int rc, per, k, exp_spd, i, j, exp_disp, exp_idx, n;
    int idx, spd, ld, disp, bsy, dn;
    bit restarted;
    rc  = (rnd > 33) ? 33 : rnd;
    per = on_p + gap_p;
    restarted = 0;
    if (rc != 0) begin
      exp_spd = (rc - 1) / 4;
      if (exp_spd > 4) exp_spd = 4;
      last_spd[inst] = exp_spd;
    end
    exp_spd = last_spd[inst];
    round = 6'(rnd);
    set_start(inst, 1'b1);
    step();
    set_start(inst, 1'b0);
    sample(inst, idx, spd, ld, disp, bsy, dn);
    $display("start inst=%0d round=%0d rc=%0d", inst, rnd, rc);
    if (rc == 0) begin
      chk("zero_done", dn, 1);
      chk("zero_load", ld, 0);
      chk("zero_disp", disp, 0);
      chk("zero_busy", bsy, 0);
      chk("zero_speed", spd, exp_spd);
      step();
      sample(inst, idx, spd, ld, disp, bsy, dn);
      chk("zero_done_clr", dn, 0);
      chk("zero_disp2", disp, 0);
      return;
    end
    chk("load_strobe", ld, 1);
    chk("load_busy", bsy, 1);
    chk("load_speed", spd, exp_spd);
    chk("load_disp", disp, 0);
    pulse = pulse_in_load;
    step();
    pulse = 1'b0;
    k = 0;
    while (1) begin
      sample(inst, idx, spd, ld, disp, bsy, dn);
      if (k == 1 + rc * per) begin
        chk("end_done", dn, 1);
        chk("end_busy", bsy, 0);
        chk("end_disp", disp, 0);
        chk("end_idx", idx, rc - 1);
        chk("end_load", ld, 0);
        $display("done inst=%0d pulses=%0d idx=%0d", inst, k, idx);
        step();
        sample(inst, idx, spd, ld, disp, bsy, dn);
        chk("end_done_clr", dn, 0);
        chk("end_idx_hold", idx, rc - 1);
        break;
      end
      if (k == 0) begin
        exp_disp = 0;
        exp_idx  = 0;
      end else begin
        j = k - 1;
        i = j / per;
        exp_idx  = i;
        exp_disp = ((j % per) < on_p) ? (1 << seg_mem[i]) : 0;
      end
      chk("play_disp", disp, exp_disp);
      chk("play_idx", idx, exp_idx);
      chk("play_busy", bsy, 1);
      chk("play_done", dn, 0);
      chk("play_load", ld, 0);
      chk("play_speed", spd, exp_spd);
      if (k == abort_at) begin
        abort = 1'b1;
        pulse = 1'b1;
        step();
        abort = 1'b0;
        pulse = 1'b0;
        sample(inst, idx, spd, ld, disp, bsy, dn);
        chk("abort_busy", bsy, 0);
        chk("abort_disp", disp, 0);
        chk("abort_done", dn, 0);
        chk("abort_speed", spd, exp_spd);
        $display("abort inst=%0d at k=%0d", inst, k);
        repeat (3) begin
          step();
          sample(inst, idx, spd, ld, disp, bsy, dn);
          chk("abort_no_done", dn, 0);
          chk("abort_idle", bsy, 0);
        end
        return;
      end
      if (k == reset_at) begin
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_zero(inst, "midreset");
        $display("reset inst=%0d at k=%0d", inst, k);
        step();
        reset = 1'b1;
        step();
        chk_zero(inst, "postreset");
        last_spd[0] = 0;
        last_spd[1] = 0;
        return;
      end
      if (restart_busy && !restarted && k == 2) begin
        round = 6'd63;
        set_start(inst, 1'b1);
        step();
        set_start(inst, 1'b0);
        round = 6'(rnd);
        restarted = 1;
        continue;
      end
      n = (spacing < 0) ? int'($urandom_range(0, 3)) : spacing;
      repeat (n) begin
        step();
        sample(inst, idx, spd, ld, disp, bsy, dn);
        chk("hold_disp", disp, exp_disp);
        chk("hold_done", dn, 0);
      end
      pulse = 1'b1;
      step();
      pulse = 1'b0;
      k++;
    end
  endtask

  initial begin
    speed_vec_t speed_tab [8];
    int idx, spd, ld, disp, bsy, dn;
    speed_tab[0] = '{4, 0};  speed_tab[1] = '{5, 1};  speed_tab[2] = '{17, 4};
    speed_tab[3] = '{33, 4}; speed_tab[4] = '{50, 4}; speed_tab[5] = '{1, 0};
    speed_tab[6] = '{9, 2};  speed_tab[7] = '{13, 3};

    reset = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0; pulse = 1'b0; round = '0;
    last_spd[0] = 0; last_spd[1] = 0;
    for (int i = 0; i < 64; i++) seg_mem[i] = 2'($urandom_range(0, 3));
    #2;
    chk_zero(0, "in_reset");
    chk_zero(1, "in_reset2");
    step(); step();
    reset = 1'b1;
    repeat (20) begin
      step();
      chk("idle_load", int'(ld1), 0);
      chk("idle_busy", int'(busy1), 0);
    end
    chk_zero(0, "idle");
    chk_zero(1, "idle2");

    // Colours {2,0,3} with a pulse every 10 cycles: 0100,0000,0001,0000,1000,0000.
    seg_mem[0] = 2'd2; seg_mem[1] = 2'd0; seg_mem[2] = 2'd3;
    play(0, 3, 1, 1, -1, -1, 0, 0, 9);

    for (int t = 0; t < 8; t++) begin
      play(0, speed_tab[t].rnd, 1, 1, 0, -1, 0, 0, 0);
      chk("tab_speed", int'(spd1), speed_tab[t].exp_speed);
      $display("speed round=%0d speed=%0d", speed_tab[t].rnd, spd1);
    end

    play(0, 50, 1, 1, -1, -1, 0, 0, 0);
    play(0, 0, 1, 1, -1, -1, 0, 0, 0);

    play(0, 5, 1, 1, 3, -1, 0, 0, -1);
    play(0, 2, 1, 1, -1, -1, 0, 0, -1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) seg_mem[i] = 2'($urandom_range(0, 3));
      play(0, int'($urandom_range(1, 12)), 1, 1, -1, -1, 0, 0, -1);
    end

    // Abort and start together while idle: start is dropped.
    round = 6'd4; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    sample(0, idx, spd, ld, disp, bsy, dn);
    chk("abort_start_busy", bsy, 0);
    chk("abort_start_load", ld, 0);
    chk("abort_start_done", dn, 0);
    step();
    sample(0, idx, spd, ld, disp, bsy, dn);
    chk("abort_start_idle", bsy, 0);
    $display("abort+start in idle busy=%0d", bsy);

    play(1, 2, 2, 1, -1, -1, 1, 1, -1);
    play(1, 2, 2, 1, -1, 3, 0, 0, -1);
    chk_zero(0, "reset_dut1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_sequencer.md
Name: flash_sequencer

Overview:
- Plays back the stored colour sequence for the current round on LEDR[3:0].
- Sits between the fsm controller, the segments array and the flash timer:
  - sets the timer speed for the round;
  - steps the segment index;
  - drives each colour on for a fixed number of timer pulses, then off for a gap;
  - reports completion to the fsm so player input can begin.

Parameters:
- ROUNDS_PER_SPEEDUP, 4: rounds played at each speed level before the level increments.
- MAX_SPEED, 3'd4: highest speed code issued (16 Hz).
- ON_PULSES, 1: timer pulses each colour stays lit (1..7).
- GAP_PULSES, 1: timer pulses of dark gap after each colour (1..7).
- MAX_ROUND, 33: segment array depth; larger round values are clamped to this.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset; all state is cleared while reset==0.
- start  in  1  single-cycle request from fsm to play the current round.
- abort  in  1  cancels playback immediately.
- round  in  6  number of colours to play (0..63, clamped to MAX_ROUND).
- pulse  in  1  tick from variable_timer.
- seg_colour  in  2  colour at seg_idx, combinational read from segments_array.
- seg_idx  out  6  segment index being played.
- speed  out  3  speed code to variable_timer.
- load_speed  out  1  one-cycle strobe to reload the timer with speed.
- disp_o  out  4  one-hot LED drive; 0 when dark.
- busy  out  1  high from start accept until done or abort.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0, async), until the next clk edge after release:
  - state=IDLE, seg_idx=0, speed=0, load_speed=0, disp_o=0, busy=0, done=0;
  - pulse counter=0.
- States: IDLE, LOAD, LEAD, ON, GAP, DONE.
- IDLE:
  - On start==1 and abort==0, latch rc=min(round,MAX_ROUND).
  - If rc==0: go to DONE, no load_speed.
  - Else: go to LOAD; speed<=min(MAX_SPEED, (rc-1)/ROUNDS_PER_SPEEDUP), registered the same edge.
  - start in any state other than IDLE is ignored.
- LOAD (1 cycle):
  - load_speed=1, busy=1; speed is already valid in this cycle.
  - Next state is LEAD, with seg_idx=0.
- LEAD: dark; waits for exactly one pulse, then goes to ON.
  - A pulse arriving in the LOAD cycle is ignored, because the timer is reloading.
- ON:
  - disp_o = 4'b0001 << seg_colour (combinational from state and seg_colour).
  - Counts pulses; on the ON_PULSES-th pulse, clears the counter and goes to GAP.
- GAP:
  - disp_o=0.
  - On the GAP_PULSES-th pulse: if seg_idx==rc-1, go to DONE; else seg_idx<=seg_idx+1 and go to ON.
- DONE (1 cycle): done=1, busy=0 → IDLE.
  - seg_idx holds its last value until the next start.
- Pulse budget:
  - Total pulses from LOAD to done = 1 + rc*(ON_PULSES+GAP_PULSES).
  - done asserts in the cycle after the final GAP pulse.
- abort:
  - From any state except IDLE, the next edge goes to IDLE.
  - disp_o=0 and busy=0 from that edge; done is not pulsed; speed is retained.
  - abort and start in the same IDLE cycle: abort wins, start is dropped.
- A pulse and an abort in the same cycle: abort wins.
- speed only changes on start acceptance; it never changes mid-round.
- Arithmetic:
  - the pulse counter is 3 bits and saturates the compare, with no wrap;
  - seg_idx never exceeds MAX_ROUND-1;
  - the division is by a constant parameter.
- Reset asserted mid-playback: outputs return to their reset values asynchronously; no done is issued.

Test Plan:
- Reset released, idle 20 cycles → all outputs 0, busy=0, no load_speed.
- Round=3, seg colours {2,0,3}, pulse every 10 cycles, defaults:
  - load_speed=1 one cycle after start, with speed=0;
  - disp_o sequence 0100, 0000, 0001, 0000, 1000, 0000;
  - done after exactly 7 pulses; seg_idx ends at 2.
- Speed mapping: round=4 → 0, 5 → 1, 17 → 4, 33 → 4, 50 (clamped to 33) → 4.
  - For round=50, playback ends with seg_idx=32 after 67 pulses.
- Round=0 → done one cycle after the start edge; no load_speed; disp_o stays 0.
- Abort during ON of index 1, round=5 → next edge disp_o=0, busy=0, no done.
  - A following start with round=2 plays from seg_idx=0.
- Edge cases, round=2, ON_PULSES=2, GAP_PULSES=1:
  - pulse in the LOAD cycle is ignored, and start re-asserted while busy is ignored;
  - each colour is lit for 2 pulses; done after 7 counted pulses.
  - Reset pulsed low mid-GAP → outputs clear immediately.
